// File: rtl/nf10_rx_pkt_buffer_pkg.sv
// nf10_rx_buf_pkg: shared types and helpers for the nf10 receive packet buffer.
//   - wr_state_t : ingress write FSM encoding
//   - tuser field offsets (length, source port, destination port)
//   - popcount() : byte count of a tstrb vector
package nf10_rx_buf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DROP  = 2'd2
  } wr_state_t;

  localparam int LEN_LO = 0;
  localparam int LEN_HI = 15;
  localparam int SRC_LO = 16;
  localparam int SRC_HI = 23;
  localparam int DST_LO = 24;
  localparam int DST_HI = 31;

  // Widest tstrb the helper accepts; callers zero-extend narrower vectors.
  localparam int STRB_MAX = 64;

  function automatic logic [15:0] popcount(input logic [STRB_MAX-1:0] v);
    logic [15:0] n;
    n = '0;
    for (int i = 0; i < STRB_MAX; i++) n = n + {15'd0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/nf10_rx_pkt_buffer_sdp_ram.sv
// nf10_sdp_ram: simple dual-port RAM, one write port, one registered read port.
//   clk             : clock
//   wr_en/addr/data : write port
//   rd_en/addr      : read request; rd_data valid one cycle later
module nf10_sdp_ram #(
  parameter int WIDTH  = 73,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/nf10_rx_pkt_buffer.sv
// nf10_rx_pkt_buffer: store-and-forward receive buffer behind a 10G MAC.
// Ingress is never back-pressured; a packet becomes visible to egress only
// once its last beat has been stored. Packets that do not fit are dropped
// whole and counted. tuser[15:0] gets the byte length, tuser[23:16] the
// source port code.
//   axi_aclk, axi_reset : clock, synchronous active-high reset
//   s_axis_*            : ingress stream (tready is 1 outside reset)
//   m_axis_*            : egress stream, tuser valid on every beat
//   drop_count          : packets dropped since reset (wraps)
module nf10_rx_pkt_buffer
  import nf10_rx_buf_pkg::*;
#(
  parameter int          C_DATA_WIDTH      = 64,
  parameter int          C_TUSER_WIDTH     = 128,
  parameter int          C_ADDR_WIDTH      = 9,
  parameter int          C_META_ADDR_WIDTH = 4,
  parameter logic [7:0]  C_SRC_PORT        = 8'h01
) (
  input  logic                      axi_aclk,
  input  logic                      axi_reset,
  input  logic [C_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_DATA_WIDTH/8-1:0] s_axis_tstrb,
  input  logic [C_TUSER_WIDTH-1:0]  s_axis_tuser,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic                      s_axis_tlast,
  output logic [C_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_DATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic [C_TUSER_WIDTH-1:0]  m_axis_tuser,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast,
  output logic [31:0]               drop_count
);

  localparam int STRB_W = C_DATA_WIDTH / 8;
  localparam int WORD_W = C_DATA_WIDTH + STRB_W + 1;
  localparam int AW     = C_ADDR_WIDTH;
  localparam int MW     = C_META_ADDR_WIDTH;
  localparam logic [AW:0] DEPTH      = {1'b1, {AW{1'b0}}};
  localparam logic [MW:0] META_DEPTH = {1'b1, {MW{1'b0}}};

  // ---------------- write side ----------------
  wr_state_t state, state_nxt;
  logic [AW:0]  wr_ptr, commit_ptr, rd_ptr;
  logic [15:0]  byte_cnt, len_nxt, strb_cnt;
  logic [C_TUSER_WIDTH-1:0] tuser_q, tuser_cur, meta_entry;
  logic [MW:0]  meta_wr, meta_rd;
  logic [C_TUSER_WIDTH-1:0] meta_mem [2**MW];
  logic [31:0]  drop_cnt;
  logic ram_full, meta_full;
  logic ram_we, sop, commit, rewind, drop_inc, meta_pop;

  assign s_axis_tready = ~axi_reset;
  assign drop_count    = drop_cnt;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign ram_full  = (wr_ptr - rd_ptr) == DEPTH;
  assign meta_full = (meta_wr - meta_rd) == META_DEPTH;
  assign strb_cnt  = popcount(STRB_MAX'(s_axis_tstrb));

  always_comb begin
    state_nxt = state;
    ram_we    = 1'b0;
    sop       = 1'b0;
    commit    = 1'b0;
    rewind    = 1'b0;
    drop_inc  = 1'b0;
    case (state)
      IDLE: if (s_axis_tvalid) begin
        if (meta_full || ram_full) begin
          if (s_axis_tlast) drop_inc  = 1'b1;
          else              state_nxt = DROP;
        end else begin
          ram_we = 1'b1;
          sop    = 1'b1;
          if (s_axis_tlast) commit    = 1'b1;
          else              state_nxt = WRITE;
        end
      end
      WRITE: if (s_axis_tvalid) begin
        if (ram_full) begin
          // Discard the partial packet; committed data stays untouched.
          rewind = 1'b1;
          if (s_axis_tlast) begin
            drop_inc  = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = DROP;
          end
        end else begin
          ram_we = 1'b1;
          if (s_axis_tlast) begin
            commit    = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      DROP: if (s_axis_tvalid && s_axis_tlast) begin
        drop_inc  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Single-beat packets commit in their first cycle, so take tuser live then.
  assign len_nxt    = (sop ? 16'd0 : byte_cnt) + strb_cnt;
  assign tuser_cur  = sop ? s_axis_tuser : tuser_q;
  assign meta_entry = {tuser_cur[C_TUSER_WIDTH-1:DST_LO], C_SRC_PORT, len_nxt};

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      byte_cnt   <= '0;
      tuser_q    <= '0;
      meta_wr    <= '0;
      meta_rd    <= '0;
      drop_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (rewind)      wr_ptr <= commit_ptr;
      else if (ram_we) wr_ptr <= wr_ptr + 1'b1;
      if (ram_we) byte_cnt <= len_nxt;
      if (sop)    tuser_q  <= s_axis_tuser;
      if (commit) begin
        commit_ptr <= wr_ptr + 1'b1;
        meta_wr    <= meta_wr + 1'b1;
      end
      if (drop_inc) drop_cnt <= drop_cnt + 32'd1;
      if (meta_pop) meta_rd  <= meta_rd + 1'b1;
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (commit) meta_mem[meta_wr[MW-1:0]] <= meta_entry;
  end

  // ---------------- read side ----------------
  logic              fetch, rd_vld, pop;
  logic [1:0]        occ;
  logic [WORD_W-1:0] rd_word, out_word, skid_word;
  logic              out_vld, skid_vld;

  nf10_sdp_ram #(.WIDTH(WORD_W), .ADDR_W(AW)) u_ram (
    .clk     (axi_aclk),
    .wr_en   (ram_we),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data ({s_axis_tlast, s_axis_tstrb, s_axis_tdata}),
    .rd_en   (fetch),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (rd_word)
  );

  assign pop      = out_vld & m_axis_tready;
  assign meta_pop = pop & out_word[WORD_W-1];

  // Credit check: output reg + skid hold two beats; a read in flight counts
  // against them. Fetch only if the word issued now is sure to find a slot.
  assign occ   = {1'b0, out_vld} + {1'b0, skid_vld} + {1'b0, rd_vld};
  assign fetch = (rd_ptr != commit_ptr) && ((occ - {1'b0, pop}) < 2'd2);

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      rd_ptr    <= '0;
      rd_vld    <= 1'b0;
      out_vld   <= 1'b0;
      skid_vld  <= 1'b0;
      out_word  <= '0;
      skid_word <= '0;
    end else begin
      rd_vld <= fetch;
      if (fetch) rd_ptr <= rd_ptr + 1'b1;
      if (!out_vld || pop) begin
        if (skid_vld) begin
          out_word <= skid_word;
          out_vld  <= 1'b1;
          skid_vld <= rd_vld;
          if (rd_vld) skid_word <= rd_word;
        end else begin
          out_vld <= rd_vld;
          if (rd_vld) out_word <= rd_word;
        end
      end else if (rd_vld) begin
        skid_vld  <= 1'b1;
        skid_word <= rd_word;
      end
    end
  end

  assign m_axis_tvalid = out_vld;
  assign m_axis_tdata  = out_word[C_DATA_WIDTH-1:0];
  assign m_axis_tstrb  = out_word[C_DATA_WIDTH +: STRB_W];
  assign m_axis_tlast  = out_vld & out_word[WORD_W-1];
  assign m_axis_tuser  = out_vld ? meta_mem[meta_rd[MW-1:0]] : '0;

endmodule

// File: tb/tb_nf10_rx_pkt_buffer.sv
// Directed bench for nf10_rx_pkt_buffer with a small-RAM build (16 beats)
// so overflow cases are reachable quickly. Egress beats are checked against
// a queue of expected beats filled by the packet driver.
module tb_nf10_rx_pkt_buffer;

  logic         axi_aclk = 1'b0;
  logic         axi_reset = 1'b1;
  logic [63:0]  s_tdata = '0;
  logic [7:0]   s_tstrb = '0;
  logic [127:0] s_tuser = '0;
  logic         s_tvalid = 1'b0;
  logic         s_tready;
  logic         s_tlast = 1'b0;
  logic [63:0]  m_tdata;
  logic [7:0]   m_tstrb;
  logic [127:0] m_tuser;
  logic         m_tvalid;
  logic         m_tready = 1'b0;
  logic         m_tlast;
  logic [31:0]  drop_count;

  nf10_rx_pkt_buffer #(
    .C_DATA_WIDTH(64), .C_TUSER_WIDTH(128), .C_ADDR_WIDTH(4),
    .C_META_ADDR_WIDTH(4), .C_SRC_PORT(8'h01)
  ) dut (
    .axi_aclk(axi_aclk), .axi_reset(axi_reset),
    .s_axis_tdata(s_tdata), .s_axis_tstrb(s_tstrb), .s_axis_tuser(s_tuser),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tstrb(m_tstrb), .m_axis_tuser(m_tuser),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
    .drop_count(drop_count)
  );

  always #5 axi_aclk = ~axi_aclk;

  typedef struct {
    logic [63:0]  d;
    logic [7:0]   s;
    logic         l;
    logic [127:0] u;
  } beat_t;

  beat_t exp_q[$];
  int n_chk = 0, n_bad = 0;
  int tx_beats = 0, rx_beats = 0, pkt_seq = 0;
  int cyc = 0, first_cyc = 0, last_cyc = 0;
  bit span_arm = 0, rand_rdy = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge axi_aclk);
    #1;
  endtask

  always @(posedge axi_aclk) begin
    cyc++;
    #1;
    if (rand_rdy) m_tready = 1'($urandom_range(0, 1));
  end

  // Scoreboard: every accepted egress beat must match the oldest expected beat.
  always @(negedge axi_aclk) begin
    if (!axi_reset && m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 1, 0);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        chk("tdata", m_tdata, e.d);
        chk("tstrb", m_tstrb, e.s);
        chk("tlast", m_tlast, e.l);
        chk("tuser", m_tuser, e.u);
      end
      rx_beats++;
      if (span_arm) begin
        first_cyc = cyc;
        span_arm  = 0;
      end
      last_cyc = cyc;
    end
  end

  // n beats, last beat carries nb bytes (1..8). keep=1 means the packet is
  // expected at egress, so its beats go to the scoreboard.
  task automatic send_pkt(input int n, input int nb, input logic [127:0] tu, input bit keep);
    logic [15:0] len;
    beat_t b;
    len = 16'((n - 1) * 8 + nb);
    pkt_seq++;
    for (int i = 0; i < n; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = {32'(pkt_seq), 32'(i)};
      s_tstrb  = (i == n - 1) ? (8'hFF >> (8 - nb)) : 8'hFF;
      s_tlast  = (i == n - 1);
      // Only the first beat's tuser should matter.
      s_tuser  = (i == 0) ? tu : ~tu;
      if (keep) begin
        b.d = s_tdata; b.s = s_tstrb; b.l = s_tlast;
        b.u = {tu[127:24], 8'h01, len};
        exp_q.push_back(b);
        tx_beats++;
      end
      step();
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic do_reset();
    axi_reset = 1'b1;
    s_tvalid  = 1'b0;
    s_tlast   = 1'b0;
    step();
    step();
    @(negedge axi_aclk);
    chk("rst_s_tready", s_tready, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tlast", m_tlast, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_m_tuser", m_tuser, 0);
    chk("rst_drop_count", drop_count, 0);
    exp_q.delete();
    tx_beats = 0;
    rx_beats = 0;
    @(posedge axi_aclk);
    #1;
    axi_reset = 1'b0;
    @(negedge axi_aclk);
    chk("s_tready_after_rst", s_tready, 1);
    step();
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 4000 && exp_q.size() != 0; i++) step();
    chk(tag, 32'(exp_q.size()), 0);
  endtask

  initial begin
    int lat, rx0, n, nb;

    // --- 8-beat packet, 60 bytes, latency ---
    do_reset();
    m_tready = 1'b1;
    send_pkt(8, 4, {96'h0, 8'h04, 24'h0}, 1);
    // Last beat accepted at the edge just passed (cycle N ends there);
    // tvalid should be high in cycle N+3, i.e. after two more edges.
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge axi_aclk);
      if (m_tvalid) break;
      @(posedge axi_aclk);
      lat++;
    end
    chk("latency_edges", 32'(lat), 2);
    chk("len_60", m_tuser[15:0], 16'd60);
    chk("src_port", m_tuser[23:16], 8'h01);
    chk("dst_port", m_tuser[31:24], 8'h04);
    wait_drain("drain_8beat");
    chk("rx_8beats", 32'(rx_beats), 8);

    // --- oversize packet dropped, following packet intact ---
    do_reset();
    m_tready = 1'b1;
    rx0 = rx_beats;
    send_pkt(20, 8, 128'h1234, 0);
    repeat (10) step();
    chk("oversize_nothing_out", 32'(rx_beats - rx0), 0);
    chk("oversize_drop_count", drop_count, 1);
    send_pkt(4, 3, 128'hABCD_0000_0000, 1);
    wait_drain("drain_after_drop");
    chk("after_drop_rx", 32'(rx_beats - rx0), 4);

    // --- meta FIFO full: 17th packet dropped, 16 come out in order ---
    do_reset();
    m_tready = 1'b0;
    for (int p = 0; p < 16; p++) send_pkt(1, 8, {96'(p), 32'h0}, 1);
    send_pkt(1, 8, 128'hDEAD, 0);
    repeat (4) step();
    chk("meta_full_drop", drop_count, 1);
    chk("held_no_egress", 32'(rx_beats), 0);
    m_tready = 1'b1;
    wait_drain("drain_16pkts");
    chk("rx_16pkts", 32'(rx_beats), 16);

    // --- random lengths, random egress ready, paced to never overflow ---
    do_reset();
    rand_rdy = 1;
    for (int p = 0; p < 200; p++) begin
      n  = $urandom_range(1, 8);
      nb = $urandom_range(1, 8);
      for (int w = 0; w < 500 && (tx_beats - rx_beats + n > 16); w++) step();
      send_pkt(n, nb, {$urandom(), $urandom(), $urandom(), $urandom()}, 1);
    end
    wait_drain("drain_random");
    rand_rdy = 0;
    #2;
    m_tready = 1'b1;
    chk("random_no_drops", drop_count, 0);
    chk("random_rx_total", 32'(rx_beats), 32'(tx_beats));

    // --- reset mid-packet while egress is active ---
    do_reset();
    m_tready = 1'b1;
    send_pkt(20, 8, 128'h5, 0);
    chk("pre_reset_drop", drop_count, 1);
    send_pkt(8, 8, 128'h77_0000_0000, 1);
    s_tvalid = 1'b1;
    s_tlast  = 1'b0;
    s_tstrb  = 8'hFF;
    s_tuser  = 128'h99_0000_0000;
    for (int i = 0; i < 3; i++) step();
    @(negedge axi_aclk);
    chk("egress_active", m_tvalid, 1);
    @(posedge axi_aclk);
    #1;
    axi_reset = 1'b1;
    s_tvalid  = 1'b0;
    step();
    exp_q.delete();
    axi_reset = 1'b0;
    @(negedge axi_aclk);
    chk("mid_rst_tvalid", m_tvalid, 0);
    chk("mid_rst_drop", drop_count, 0);
    step();
    rx0 = rx_beats;
    send_pkt(3, 5, 128'h42_0000_0000, 1);
    wait_drain("drain_post_reset");
    chk("post_reset_rx", 32'(rx_beats - rx0), 3);

    // --- single-beat packets every cycle: egress sustains 1 pkt/cycle ---
    do_reset();
    m_tready = 1'b1;
    span_arm = 1;
    for (int p = 0; p < 10; p++) send_pkt(1, (p % 8) + 1, {96'(p), 32'h0}, 1);
    wait_drain("drain_b2b");
    chk("b2b_rx", 32'(rx_beats), 10);
    chk("b2b_span", 32'(last_cyc - first_cyc), 9);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/nf10_rx_pkt_buffer.md
# nf10_rx_pkt_buffer

Store-and-forward receive buffer placed directly downstream of the 10G port's master AXI4-Stream output (64-bit data, 128-bit tuser). It accepts beats unconditionally, since the MAC cannot be back-pressured, and holds each packet until its last beat arrives. It fills in the tuser length and source-port fields, then forwards only complete packets. A packet is dropped whole, and counted, if buffer space runs out.

## Interface
- C_DATA_WIDTH, 64, tdata width; tstrb is C_DATA_WIDTH/8.
- C_TUSER_WIDTH, 128, tuser width.
- C_ADDR_WIDTH, 9, data RAM address bits; depth 2^C_ADDR_WIDTH beats; legal range 4..12.
- C_META_ADDR_WIDTH, 4, packet-metadata FIFO address bits (16 packets).
- C_SRC_PORT, 8'h01, one-hot port code written into tuser[23:16].
- axi_aclk  in  1  sole clock; all logic on rising edge.
- axi_reset  in  1  synchronous, active-high reset.
- s_axis_tdata  in  C_DATA_WIDTH  ingress data.
- s_axis_tstrb  in  C_DATA_WIDTH/8  byte enables, contiguous from bit 0.
- s_axis_tuser  in  C_TUSER_WIDTH  ingress sideband, sampled on first beat.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tready  out  1  tied 1 whenever not in reset.
- s_axis_tlast  in  1  end of packet.
- m_axis_tdata  out  C_DATA_WIDTH  egress data.
- m_axis_tstrb  out  C_DATA_WIDTH/8  egress byte enables.
- m_axis_tuser  out  C_TUSER_WIDTH  egress sideband, valid on every beat of the packet.
- m_axis_tvalid  out  1  egress beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  egress end of packet.
- drop_count  out  32  packets dropped since reset; wraps.

## Operation
- Write FSM states IDLE, WRITE, DROP.
- IDLE, valid beat arrives:
  - If the meta FIFO is full or the data RAM is full: go to DROP, or stay in IDLE and count one drop if tlast is also set.
  - Otherwise: write the beat, capture tuser, start the byte counter at popcount(tstrb), then go to WRITE, or commit immediately if tlast is set.
- WRITE, valid beat:
  - RAM full: rewind wr_ptr to commit_ptr. Go to DROP, or go to IDLE and count the drop if tlast.
  - Otherwise: write the beat and accumulate the byte count. On tlast, commit.
- DROP: discard beats. On tlast, go to IDLE and increment drop_count.
- Commit:
  - commit_ptr <= wr_ptr+1.
  - Push {tuser[127:24], C_SRC_PORT, byte_len[15:0]} into the meta FIFO.
  - FSM returns to IDLE.
- RAM word format is {tlast, tstrb, tdata}. Fullness is computed as (wr_ptr - rd_ptr) == 2^C_ADDR_WIDTH, using C_ADDR_WIDTH+1-bit pointers.
- Read side: the reader may fetch only up to commit_ptr, so uncommitted beats are never visible. m_axis_tuser holds the meta FIFO head. The head is popped when the tlast beat is accepted (tvalid&tready&tlast).
- Simultaneous read and write is allowed every cycle. A drop rewinds only wr_ptr, so packets already in flight on the read side are unaffected.
- Reset mid-operation: all pointers, both FSMs, the meta FIFO and drop_count clear. Any partial or committed contents are lost. Upstream shares this reset, so the first beat after reset is treated as SOP.

## Timing
- Reset values: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata/tstrb/tuser=0, s_axis_tready=0 during reset and 1 from the cycle after, drop_count=0.
- RAM read latency is 1 cycle, followed by a 2-entry skid/output register. m_axis_tvalid and the data path are fully registered.
- Latency: tlast accepted in cycle N → commit visible N+1 → m_axis_tvalid rises at N+3 when the output is idle.
- Throughput is one beat per cycle on both sides with tready held high. m_axis_tvalid, once high, holds data stable until tready (AXI rule).
- Back-to-back packets have no idle gap on egress when the next packet is committed.
- m_axis_tuser[15:0] gives the byte length. Maximum length is 2^C_ADDR_WIDTH×8 bytes ≤ 32768, so it fits in 16 bits.

## Structure
- Package nf10_rx_buf_pkg holds:
  - write-FSM state encoding;
  - tuser field offsets: LEN_LO=0, LEN_HI=15, SRC_LO=16, SRC_HI=23, DST_LO=24, DST_HI=31;
  - a popcount function for tstrb.
- Sub-module nf10_sdp_ram: simple dual-port RAM, one write port, one registered read port, width C_DATA_WIDTH+C_DATA_WIDTH/8+1. It is used for the data store; the meta FIFO stays inline.

## Test plan
- One 8-beat packet, last tstrb=8'h0F, tuser[31:24]=8'h04, m_tready=1 → 8 beats out, tuser[15:0]=16'd60, [23:16]=8'h01, [31:24]=8'h04; tvalid rises 3 cycles after input tlast.
- C_ADDR_WIDTH=4, send a 20-beat packet → nothing emitted, drop_count=1. A following 4-beat packet emerges intact.
- Fill to 16 packets with m_tready=0, then send a 17th → 17th dropped (drop_count=1). Release tready → 16 packets out in order.
- Random m_tready at 50% with 200 random-length packets → byte-exact match to a scoreboard, no drops when the buffer is sized adequately.
- Assert axi_reset for 1 cycle mid-packet during egress → tvalid=0 next cycle, drop_count=0. A fresh packet afterwards passes correctly.
- Single-beat packets back-to-back every cycle → output sustains 1 packet/cycle, each with tlast=1 and the correct length.
